axis_xscaler: RTL

//  Nearest-neighbour horizontal resampler for 8-bit AXI4-Stream video (tuser=SOF, tlast=EOL).

---
 rtl/axis_video_pkg.sv | 25 ++
 rtl/axis_reg_slice.sv | 42 ++++
 rtl/axis_xscaler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axis_video_pkg.sv
// Shared definitions for the AXI4-Stream video scaler chain (yscaler / xscaler).
// Holds the common state encoding, default geometry widths and the pixel type.
package axis_video_pkg;

    // Default pixel and image-dimension widths used across the scaler chain
    localparam int unsigned C_PIXEL_WIDTH_DEF = 8;
    localparam int unsigned C_IMG_WBITS_DEF   = 12;

    // One 8-bit pixel sample
    typedef logic [C_PIXEL_WIDTH_DEF-1:0] pixel_t;

    // Line-processing states shared by the horizontal and vertical scalers
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // discard input until an accepted start-of-frame
        S_RUN   = 2'd1,   // hold / emit / retire pixels via the DDA
        S_PAD   = 2'd2,   // input line ended early: replicate last pixel
        S_DRAIN = 2'd3    // output line complete: drop input until EOL
    } vid_state_t;

    // True when a width pair cannot produce a meaningful line
    function automatic logic width_is_zero(input logic [C_IMG_WBITS_DEF-1:0] w);
        return (w == '0);
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry valid/ready output register.
// Loads whenever the slot is empty or its current contents are being taken,
// so a full-rate stream passes with one cycle of latency and no bubbles.
module axis_reg_slice
    import axis_video_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = C_PIXEL_WIDTH_DEF + 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    // upstream side
    input  logic                    i_valid,
    input  logic [C_DATA_WIDTH-1:0] i_data,
    output logic                    o_ready,
    // downstream side
    output logic                    o_valid,
    output logic [C_DATA_WIDTH-1:0] o_data,
    input  logic                    i_ready
);

    logic                    r_valid;
    logic [C_DATA_WIDTH-1:0] r_data;

    // Slot can accept when empty or when the held beat leaves this cycle
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Output slot register; contents stay stable while valid and not taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/axis_xscaler.sv
// Nearest-neighbour horizontal resampler for 8-bit AXI4-Stream video.
// Every ori_width-pixel input line becomes exactly scale_width output pixels
// using an error-accumulating DDA; short lines are padded, long lines drained.
module axis_xscaler
    import axis_video_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = C_PIXEL_WIDTH_DEF,
    parameter int unsigned C_IMG_WBITS   = C_IMG_WBITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [C_IMG_WBITS-1:0]   ori_width,
    input  logic [C_IMG_WBITS-1:0]   scale_width,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam int unsigned C_SLOT_W = C_PIXEL_WIDTH + 2;

    // FSM and datapath registers
    vid_state_t               r_state;
    logic                     r_en;      // low for the first cycle after reset release
    logic                     r_held;    // a source pixel is currently held
    logic [C_PIXEL_WIDTH-1:0] r_pix;     // held source pixel
    logic                     r_last;    // held pixel carried input tlast
    logic                     r_first;   // next emit is j=0 of the first line of a frame
    logic [C_IMG_WBITS-1:0]   r_j;       // output pixel index within the line
    logic [C_IMG_WBITS:0]     r_err;     // DDA error: j*ori_width - i*scale_width
    logic [C_IMG_WBITS-1:0]   r_ow;      // latched ori_width
    logic [C_IMG_WBITS-1:0]   r_sw;      // latched scale_width

    // Combinational step signals
    logic                     w_slot_rdy;
    logic                     w_emit;
    logic [C_IMG_WBITS-1:0]   w_j_nx;
    logic [C_IMG_WBITS:0]     w_err_em;
    logic                     w_done;
    logic                     w_over;
    logic                     w_retire;
    logic                     w_to_pad;
    logic                     w_s_rdy;
    logic                     w_acc;
    logic                     w_sof;
    logic                     w_zero;
    logic [C_SLOT_W-1:0]      w_slot_in;
    logic [C_SLOT_W-1:0]      w_slot_out;

    // One DDA step: optional emit, then decide whether the held pixel retires
    always_comb begin
        w_emit   = r_held && w_slot_rdy &&
                   ((r_state == S_PAD) || (r_err < {1'b0, r_sw}));
        w_j_nx   = r_j + {{(C_IMG_WBITS-1){1'b0}}, w_emit};
        w_err_em = r_err + (w_emit ? {1'b0, r_ow} : '0);
        // Output line complete on the emit that reaches scale_width
        w_done   = w_emit && (w_j_nx == r_sw);
        // Error says the next output belongs to a later source pixel
        w_over   = r_held && (r_state == S_RUN) && (w_err_em >= {1'b0, r_sw});
        // An EOL pixel never retires on error alone; it pads instead
        w_retire = w_done || (w_over && !r_last);
        w_to_pad = w_over && r_last && !w_done;

        case (r_state)
            S_IDLE,
            S_DRAIN: w_s_rdy = 1'b1;
            S_RUN:   w_s_rdy = !r_held || w_retire;
            default: w_s_rdy = w_retire;
        endcase
        w_s_rdy = w_s_rdy && r_en;

        w_acc  = s_axis_tvalid && w_s_rdy;
        w_sof  = w_acc && s_axis_tuser;
        w_zero = width_is_zero(ori_width) || width_is_zero(scale_width);

        w_slot_in = {r_first, w_done, r_pix};
    end

    assign s_axis_tready = w_s_rdy;

    // Line/frame state machine, DDA counters and held-pixel register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_held  <= 1'b0;
            r_pix   <= '0;
            r_last  <= 1'b0;
            r_first <= 1'b0;
            r_j     <= '0;
            r_err   <= '0;
            r_ow    <= '0;
            r_sw    <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_sof) begin
                // Start of frame from any state: re-latch geometry, restart line
                r_ow   <= ori_width;
                r_sw   <= scale_width;
                r_j    <= '0;
                r_err  <= '0;
                r_pix  <= s_axis_tdata;
                r_last <= s_axis_tlast;
                if (w_zero) begin
                    r_state <= S_IDLE;
                    r_held  <= 1'b0;
                    r_first <= 1'b0;
                end else begin
                    r_state <= S_RUN;
                    r_held  <= 1'b1;
                    r_first <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_held <= 1'b0;
                    end
                    S_DRAIN: begin
                        if (w_acc && s_axis_tlast) begin
                            r_state <= S_RUN;
                            r_j     <= '0;
                            r_err   <= '0;
                        end
                    end
                    default: begin
                        if (w_emit) begin
                            r_first <= 1'b0;
                        end
                        if (w_done) begin
                            // Output line finished; next line starts from zero
                            r_j   <= '0;
                            r_err <= '0;
                            if (r_last) begin
                                r_state <= S_RUN;
                                r_held  <= w_acc;
                                if (w_acc) begin
                                    r_pix  <= s_axis_tdata;
                                    r_last <= s_axis_tlast;
                                end
                            end else if (w_acc && s_axis_tlast) begin
                                // Surplus pixel taken this cycle was the EOL
                                r_state <= S_RUN;
                                r_held  <= 1'b0;
                            end else begin
                                r_state <= S_DRAIN;
                                r_held  <= 1'b0;
                            end
                        end else if (w_retire) begin
                            r_j    <= w_j_nx;
                            r_err  <= w_err_em - {1'b0, r_sw};
                            r_held <= w_acc;
                            if (w_acc) begin
                                r_pix  <= s_axis_tdata;
                                r_last <= s_axis_tlast;
                            end
                        end else if (!r_held) begin
                            if (w_acc) begin
                                r_held <= 1'b1;
                                r_pix  <= s_axis_tdata;
                                r_last <= s_axis_tlast;
                            end
                        end else begin
                            r_j   <= w_j_nx;
                            r_err <= w_err_em;
                            if (w_to_pad) begin
                                r_state <= S_PAD;
                            end
                        end
                    end
                endcase
            end
        end
    end

    axis_reg_slice #(
        .C_DATA_WIDTH (C_SLOT_W)
    ) u_slot (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_valid (w_emit),
        .i_data  (w_slot_in),
        .o_ready (w_slot_rdy),
        .o_valid (m_axis_tvalid),
        .o_data  (w_slot_out),
        .i_ready (m_axis_tready)
    );

    assign m_axis_tuser = w_slot_out[C_SLOT_W-1];
    assign m_axis_tlast = w_slot_out[C_SLOT_W-2];
    assign m_axis_tdata = w_slot_out[C_PIXEL_WIDTH-1:0];

endmodule
